// File: rtl/block_nest_pkg.sv
// Shared definitions for the begin/end nesting checker: word-FSM state codes,
// ASCII constants for the keyword letters and a lower-case helper.
package block_nest_pkg;

    localparam int unsigned ST_W = 4;

    typedef logic [ST_W-1:0] word_state_t;

    // Word FSM states; each prefix state means "the word so far matches this keyword prefix"
    localparam word_state_t ST_IDLE  = 4'd0;
    localparam word_state_t ST_B     = 4'd1;
    localparam word_state_t ST_BE    = 4'd2;
    localparam word_state_t ST_BEG   = 4'd3;
    localparam word_state_t ST_BEGI  = 4'd4;
    localparam word_state_t ST_BEGIN = 4'd5;
    localparam word_state_t ST_E     = 4'd6;
    localparam word_state_t ST_EN    = 4'd7;
    localparam word_state_t ST_END   = 4'd8;
    localparam word_state_t ST_OTHER = 4'd9;

    // Keyword letters in lower case; input is folded to lower case before matching
    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_E = 8'h65;
    localparam logic [7:0] CH_G = 8'h67;
    localparam logic [7:0] CH_I = 8'h69;
    localparam logic [7:0] CH_N = 8'h6E;
    localparam logic [7:0] CH_D = 8'h64;

    localparam logic [7:0] CH_UP_A   = 8'h41;
    localparam logic [7:0] CH_UP_Z   = 8'h5A;
    localparam logic [7:0] CASE_BIT  = 8'h20;

    // Fold an ASCII upper-case letter to lower case; all other codes pass through
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if ((c >= CH_UP_A) && (c <= CH_UP_Z)) begin
            return c | CASE_BIT;
        end
        return c;
    endfunction

endpackage

// File: rtl/block_word_matcher.sv
// Word FSM for the nesting checker: recognises "begin"/"end" (any case) between
// separators. Provisional flags and commit pulses reflect the state the FSM
// moves to on the current accepted char.
module block_word_matcher
    import block_nest_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] ch,
    output logic       is_begin_c,
    output logic       is_end_c,
    output logic       commit_begin_c,
    output logic       commit_end_c,
    output logic       commit_word_c
);

    word_state_t state_q, state_d;
    logic [7:0]  lc;

    // Word state register; reset discards any partial word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and commit decode
    always_comb begin
        state_d        = state_q;
        commit_begin_c = 1'b0;
        commit_end_c   = 1'b0;
        commit_word_c  = 1'b0;
        lc             = to_lower(ch);
        if (in_valid) begin
            if (ch == SEP_CHAR) begin
                state_d        = ST_IDLE;
                commit_begin_c = (state_q == ST_BEGIN);
                commit_end_c   = (state_q == ST_END);
                commit_word_c  = (state_q != ST_IDLE);
            end else begin
                state_d = ST_OTHER;
                case (state_q)
                    ST_IDLE: begin
                        if (lc == CH_B) state_d = ST_B;
                        else if (lc == CH_E) state_d = ST_E;
                    end
                    ST_B:    if (lc == CH_E) state_d = ST_BE;
                    ST_BE:   if (lc == CH_G) state_d = ST_BEG;
                    ST_BEG:  if (lc == CH_I) state_d = ST_BEGI;
                    ST_BEGI: if (lc == CH_N) state_d = ST_BEGIN;
                    ST_E:    if (lc == CH_N) state_d = ST_EN;
                    ST_EN:   if (lc == CH_D) state_d = ST_END;
                    default: state_d = ST_OTHER;
                endcase
            end
        end
    end

    assign is_begin_c = (state_d == ST_BEGIN);
    assign is_end_c   = (state_d == ST_END);

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker. Holds the committed depth, sticky error
// and registered result/depth outputs; keyword recognition lives in
// block_word_matcher. Optional statistics outputs (max_depth, word_cnt) are
// enabled by defining BLOCK_NEST_STATS_EN.
module block_nest_checker
    import block_nest_pkg::*;
#(
    parameter int unsigned DEPTH_W  = 8,
    parameter logic [7:0]  SEP_CHAR = 8'h20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               error
`ifdef BLOCK_NEST_STATS_EN
    ,
    output logic [DEPTH_W-1:0] max_depth,
    output logic [15:0]        word_cnt
`endif
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;

    logic is_begin_c, is_end_c, commit_begin_c, commit_end_c, commit_word_c;

    logic [DEPTH_W-1:0] cdepth_q, cdepth_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               error_q, error_d;
    logic               result_q, result_d;

    block_word_matcher #(
        .SEP_CHAR(SEP_CHAR)
    ) u_matcher (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .ch            (in),
        .is_begin_c    (is_begin_c),
        .is_end_c      (is_end_c),
        .commit_begin_c(commit_begin_c),
        .commit_end_c  (commit_end_c),
        .commit_word_c (commit_word_c)
    );

    // Committed depth, sticky error and effective (provisional) depth
    always_comb begin
        cdepth_d = cdepth_q;
        error_d  = error_q;
        if (commit_begin_c) begin
            if (cdepth_q == DEPTH_MAX) error_d = 1'b1;
            else cdepth_d = cdepth_q + DEPTH_W'(1);
        end
        if (commit_end_c) begin
            if (cdepth_q == DEPTH_ZERO) error_d = 1'b1;
            else cdepth_d = cdepth_q - DEPTH_W'(1);
        end
        depth_d = cdepth_d;
        if (is_begin_c && (cdepth_d != DEPTH_MAX)) depth_d = cdepth_d + DEPTH_W'(1);
        if (is_end_c && (cdepth_d != DEPTH_ZERO)) depth_d = cdepth_d - DEPTH_W'(1);
        // A pending "end" at depth 0 already unbalances the stream even though depth shows 0
        result_d = !error_d && (depth_d == DEPTH_ZERO) &&
                   !(is_end_c && (cdepth_d == DEPTH_ZERO));
    end

    // Core registers; only an accepted char advances them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdepth_q <= DEPTH_ZERO;
            depth_q  <= DEPTH_ZERO;
            error_q  <= 1'b0;
            result_q <= 1'b1;
        end else if (in_valid) begin
            cdepth_q <= cdepth_d;
            depth_q  <= depth_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign depth  = depth_q;
    assign error  = error_q;

`ifdef BLOCK_NEST_STATS_EN
    logic [DEPTH_W-1:0] max_q, max_d;
    logic [15:0]        wcnt_q, wcnt_d;

    // Peak committed depth and count of non-empty committed words
    always_comb begin
        max_d  = (cdepth_d > max_q) ? cdepth_d : max_q;
        wcnt_d = wcnt_q + 16'(commit_word_c);
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q  <= DEPTH_ZERO;
            wcnt_q <= 16'd0;
        end else if (in_valid) begin
            max_q  <= max_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign max_depth = max_q;
    assign word_cnt  = wcnt_q;
`endif

endmodule

// File: tb/tb_block_nest_checker.sv
// Scoreboard bench for block_nest_checker: two instances (DEPTH_W=8 and 2) see
// the same char stream; a word-level reference model queues expected outputs
// and a monitor compares them one cycle after each accepted char.
module tb_block_nest_checker;

    typedef struct {
        int result;
        int depth;
        int error;
        int maxd;
        int wcnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_ch = 8'h00;

    logic       r0, e0, r1, e1;
    logic [7:0] d0;
    logic [1:0] d1;
`ifdef BLOCK_NEST_STATS_EN
    logic [7:0]  md0;
    logic [15:0] wc0, wc1;
    logic [1:0]  md1;
`endif

    always #5 clk = ~clk;

    block_nest_checker #(.DEPTH_W(8), .SEP_CHAR(8'h20)) dut0 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in(in_ch),
        .result(r0), .depth(d0), .error(e0)
`ifdef BLOCK_NEST_STATS_EN
        , .max_depth(md0), .word_cnt(wc0)
`endif
    );

    block_nest_checker #(.DEPTH_W(2), .SEP_CHAR(8'h20)) dut1 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in(in_ch),
        .result(r1), .depth(d1), .error(e1)
`ifdef BLOCK_NEST_STATS_EN
        , .max_depth(md1), .word_cnt(wc1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model (word level) ----------------
    int          maxv[2] = '{255, 3};
    int          cd[2];
    int          mx[2];
    int          wc[2];
    bit          er[2];
    byte unsigned word[$];
    exp_t        q0[$];
    exp_t        q1[$];

    function automatic byte unsigned lc(input byte unsigned c);
        if (c >= 8'd65 && c <= 8'd90) return c + 8'd32;
        return c;
    endfunction

    function automatic bit word_is(input string kw);
        if (word.size() != kw.len()) return 1'b0;
        for (int i = 0; i < kw.len(); i++)
            if (lc(word[i]) != kw[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t x;
        int   eff;
        bit   pend_end;
        eff = cd[k];
        pend_end = word_is("end");
        if (word_is("begin")) eff = (cd[k] + 1 > maxv[k]) ? maxv[k] : cd[k] + 1;
        else if (pend_end) eff = (cd[k] > 0) ? cd[k] - 1 : 0;
        x.result = (!er[k] && eff == 0 && !(pend_end && cd[k] == 0)) ? 1 : 0;
        x.depth  = eff;
        x.error  = er[k] ? 1 : 0;
        x.maxd   = mx[k];
        x.wcnt   = wc[k];
        return x;
    endfunction

    task automatic model_reset();
        word.delete();
        for (int k = 0; k < 2; k++) begin
            cd[k] = 0; mx[k] = 0; wc[k] = 0; er[k] = 1'b0;
        end
    endtask

    task automatic model_char(input byte unsigned c);
        if (c == 8'h20) begin
            for (int k = 0; k < 2; k++) begin
                if (word_is("begin")) begin
                    if (cd[k] == maxv[k]) er[k] = 1'b1; else cd[k]++;
                end else if (word_is("end")) begin
                    if (cd[k] == 0) er[k] = 1'b1; else cd[k]--;
                end
                if (word.size() > 0) wc[k] = (wc[k] + 1) % 65536;
                if (cd[k] > mx[k]) mx[k] = cd[k];
            end
            word.delete();
        end else begin
            word.push_back(c);
        end
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    bit acc = 1'b0;
    always @(posedge clk) acc <= in_valid && rst_n;

    // Monitor: one expected entry per accepted char, compared after the edge
    always @(negedge clk) begin
        exp_t x;
        if (acc) begin
            if (q0.size() == 0 || q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underrun: got empty queue expected an entry");
            end else begin
                x = q0.pop_front();
                chk("dut0.result", int'(r0), x.result);
                chk("dut0.depth",  int'(d0), x.depth);
                chk("dut0.error",  int'(e0), x.error);
`ifdef BLOCK_NEST_STATS_EN
                chk("dut0.max_depth", int'(md0), x.maxd);
                chk("dut0.word_cnt",  int'(wc0), x.wcnt);
`endif
                x = q1.pop_front();
                chk("dut1.result", int'(r1), x.result);
                chk("dut1.depth",  int'(d1), x.depth);
                chk("dut1.error",  int'(e1), x.error);
`ifdef BLOCK_NEST_STATS_EN
                chk("dut1.max_depth", int'(md1), x.maxd);
                chk("dut1.word_cnt",  int'(wc1), x.wcnt);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_char(input byte unsigned c);
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = c;
        model_char(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_ch    = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic put_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (gaps) idle(int'($urandom_range(1, 2)));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset.result0", int'(r0), 1);
        chk("reset.depth0",  int'(d0), 0);
        chk("reset.error0",  int'(e0), 0);
        chk("reset.result1", int'(r1), 1);
        chk("reset.depth1",  int'(d1), 0);
        chk("reset.error1",  int'(e1), 0);
`ifdef BLOCK_NEST_STATS_EN
        chk("reset.max_depth0", int'(md0), 0);
        chk("reset.word_cnt0",  int'(wc0), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    string pool[14] = '{"begin", "BEGIN", "bEgIn", "end", "END", "eNd", "beginx",
                        "endA", "beg", "en", "x1", "9end", "begins", "ends"};

    initial begin
        string w;
        do_reset();

        // "end" at depth 0: pending result 0, error on commit
        put_str("end begin end ", 1'b0);
        do_reset();
        put_str("bEgin end ", 1'b0);
        do_reset();
        // withdrawn keyword and extended "end"
        put_str("beginx endA ", 1'b0);
        do_reset();
        // saturation of the narrow instance
        put_str("begin begin begin begin ", 1'b0);
        do_reset();
        // reset in the middle of a word
        put_str("beg", 1'b0);
        do_reset();
        put_str("end ", 1'b0);
        do_reset();
        // idle cycles between every char, plus doubled separators
        put_str("begin  end ", 1'b1);
        idle(2);
        do_reset();

        // randomized word stream, biased towards keywords
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                w = "";
                for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                    case ($urandom_range(0, 7))
                        0: w = {w, "b"};
                        1: w = {w, "E"};
                        2: w = {w, "n"};
                        3: w = {w, "d"};
                        4: w = {w, "g"};
                        5: w = {w, "I"};
                        6: w = {w, "#"};
                        default: w = {w, "z"};
                    endcase
                end
            end else begin
                w = pool[$urandom_range(0, 13)];
            end
            put_str(w, $urandom_range(0, 3) == 0);
            put_str(($urandom_range(0, 7) == 0) ? "  " : " ", 1'b0);
        end
        idle(3);
        chk("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
